// File: rtl/reg32_mult32to1.sv
// Thirty-two-entry, 32-bit register file: one synchronous write port, two combinational
// read ports, with entry 0 hardwired to zero.
module reg32_mult32to1 (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic [4:0]  writeaddr,
  input  logic [31:0] writedata,
  input  logic [4:0]  readaddr1,
  output logic [31:0] readdata1,
  input  logic [4:0]  readaddr2,
  output logic [31:0] readdata2
);

  localparam int unsigned Depth = 32;
  localparam int unsigned Width = 32;

  logic [Width-1:0] words [Depth];

  // r0 has no storage; reads of address 0 see the constant.
  assign words[0] = '0;

  for (genvar i = 1; i < Depth; i++) begin : g_word
    logic             load;
    logic [Width-1:0] word_q;

    assign load = write && (writeaddr == 5'(i));

    // Reset wins over a write presented on the same edge.
    always_ff @(posedge clock) begin
      if (reset) begin
        word_q <= '0;
      end else if (load) begin
        word_q <= writedata;
      end
    end

    assign words[i] = word_q;
  end

  // Two independent 32:1 read multiplexers; no write-to-read bypass.
  always_comb begin
    readdata1 = words[readaddr1];
    readdata2 = words[readaddr2];
  end

endmodule

// File: tb/tb_reg32_mult32to1.sv
// Self-checking bench for reg32_mult32to1: directed cases plus random traffic
// compared against an array-based register file model.
module tb_reg32_mult32to1;

  logic        clock;
  logic        reset;
  logic        write;
  logic [4:0]  writeaddr;
  logic [31:0] writedata;
  logic [4:0]  readaddr1;
  logic [31:0] readdata1;
  logic [4:0]  readaddr2;
  logic [31:0] readdata2;

  logic [31:0] model [32];
  int          checks;
  int          errors;

  reg32_mult32to1 dut (
    .clock     (clock),
    .reset     (reset),
    .write     (write),
    .writeaddr (writeaddr),
    .writedata (writedata),
    .readaddr1 (readaddr1),
    .readdata1 (readdata1),
    .readaddr2 (readaddr2),
    .readdata2 (readdata2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, "_rd1"}, readdata1, model[readaddr1]);
    check({tag, "_rd2"}, readdata2, model[readaddr2]);
  endtask

  // One clock edge with the given controls; the model follows the register-file rules.
  task automatic cycle(input logic rst, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd);
    reset     = rst;
    write     = w;
    writeaddr = wa;
    writedata = wd;
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
    reset = 1'b0;
    write = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      readaddr1 = 5'(i);
      readaddr2 = 5'(31 - i);
      check_reads(tag);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    write     = 1'b0;
    writeaddr = '0;
    writedata = '0;
    readaddr1 = '0;
    readaddr2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset clears everything.
    cycle(1'b1, 1'b0, 5'd0, 32'h0);
    sweep("reset");

    // Basic write/read on both ports in the same cycle.
    cycle(1'b0, 1'b1, 5'd1, 32'd5);
    cycle(1'b0, 1'b1, 5'd31, 32'hDEADBEEF);
    readaddr1 = 5'd1;
    readaddr2 = 5'd31;
    #1;
    check("basic_r1", readdata1, 32'd5);
    check("basic_r31", readdata2, 32'hDEADBEEF);

    // r0 ignores writes.
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    readaddr1 = 5'd0;
    #1;
    check("r0_hardwire", readdata1, 32'h0);
    sweep("r0_others");

    // Write enable low: r7 unchanged.
    cycle(1'b0, 1'b1, 5'd7, 32'd11);
    cycle(1'b0, 1'b0, 5'd7, 32'd99);
    readaddr1 = 5'd7;
    #1;
    check("wen_low", readdata1, 32'd11);

    // No bypass: old value before the edge, new one after.
    reset     = 1'b0;
    write     = 1'b1;
    writeaddr = 5'd7;
    writedata = 32'd99;
    #1;
    check("nobypass_before", readdata1, 32'd11);
    @(posedge clock);
    #1;
    write = 1'b0;
    model[7] = 32'd99;
    check("nobypass_after", readdata1, 32'd99);

    // Reset beats a simultaneous write, and clears earlier writes.
    cycle(1'b1, 1'b1, 5'd3, 32'd42);
    readaddr1 = 5'd3;
    #1;
    check("rst_priority", readdata1, 32'h0);
    cycle(1'b0, 1'b1, 5'd3, 32'd42);
    #1;
    check("r3_written", readdata1, 32'd42);
    cycle(1'b1, 1'b0, 5'd0, 32'h0);
    #1;
    check("rst_after_write", readdata1, 32'h0);

    // Full sweep: index*3+1 into every register.
    for (int i = 1; i < 32; i++) cycle(1'b0, 1'b1, 5'(i), 32'(i * 3 + 1));
    for (int i = 0; i < 32; i++) begin
      readaddr1 = 5'(i);
      readaddr2 = 5'(31 - i);
      #1;
      check("sweep_p1", readdata1, (i == 0) ? 32'h0 : 32'(i * 3 + 1));
      check("sweep_p2", readdata2, (i == 31) ? 32'h0 : 32'((31 - i) * 3 + 1));
    end

    // Random traffic with occasional resets; reads checked before and after each edge.
    for (int n = 0; n < 400; n++) begin
      readaddr1 = 5'($urandom_range(0, 31));
      readaddr2 = 5'($urandom_range(0, 31));
      check_reads("rand_pre");
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom_range(0, 31)), $urandom);
      check_reads("rand_post");
    end
    sweep("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
